// File: rtl/heu_eq.sv
`default_nettype none
// ============================================================================
// Module   : heu_eq
// Purpose  : Histogram equalisation of one 20x20 8-bit window (5 beats x 80 px)
//            using a 256-bin histogram / in-place CDF; result held until taken.
// Option   : define HEU_BYPASS_EN to add a 'bypass' port that forwards the raw
//            window straight to the output.
// Revision : 1.0 - initial release
// ============================================================================
module heu_eq #(
    parameter int BEATS    = 5,
    parameter int BEAT_PIX = 80,
    parameter int NPIX     = BEATS * BEAT_PIX
) (
    input  logic                                clk,
    input  logic                                rst,
`ifdef HEU_BYPASS_EN
    input  logic                                bypass,
`endif
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [BEAT_PIX-1:0][7:0]            in_beat,
    input  logic                                rdn_in_ready,
    output logic                                out_valid,
    output logic [BEATS-1:0][BEAT_PIX-1:0][7:0] out_img
);

    localparam int BW = $clog2(BEATS);
    localparam int PW = $clog2(NPIX);
    localparam int HW = $clog2(NPIX + 1);
    localparam int MW = HW + 8;

    localparam logic [BW-1:0] C_LAST_BEAT = BW'(BEATS - 1);
    localparam logic [PW-1:0] C_LAST_PIX  = PW'(NPIX - 1);
    localparam logic [PW-1:0] C_LAST_BIN  = PW'(255);

    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_HIST = 3'd1,
        S_CDF  = 3'd2,
        S_MAP  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [BW-1:0]            r_beat_cnt;
    logic [PW-1:0]            r_pix_cnt;
    logic [HW-1:0]            r_acc;
    logic [NPIX-1:0][7:0]     r_img;
    logic [255:0][HW-1:0]     r_hist;

    logic                     w_accept;
    logic                     w_last_beat;
    logic                     w_bypass;
    logic [7:0]               w_pix;
    logic [7:0]               w_bin;
    logic [HW-1:0]            w_hist_pix;
    logic [HW-1:0]            w_cdf_sum;
    logic [MW-1:0]            w_prod;
    logic [7:0]               w_map;

`ifdef HEU_BYPASS_EN
    assign w_bypass = bypass;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_accept    = in_valid && (r_state == S_LOAD);
    assign w_last_beat = (r_beat_cnt == C_LAST_BEAT);

    // Current pixel and the histogram/CDF bin it selects
    assign w_pix      = r_img[r_pix_cnt];
    assign w_hist_pix = r_hist[w_pix];
    assign w_bin      = r_pix_cnt[7:0];
    assign w_cdf_sum  = r_hist[w_bin] + r_acc;

    // cdf*255/NPIX; cdf <= NPIX so the quotient always fits in 8 bits
    assign w_prod = MW'(w_hist_pix) * MW'(255);
    assign w_map  = 8'(w_prod / MW'(NPIX));

    assign out_img = r_img;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (w_accept && w_last_beat) begin
                    w_next = w_bypass ? S_OUT : S_HIST;
                end
            end
            S_HIST: begin
                if (r_pix_cnt == C_LAST_PIX) begin
                    w_next = S_CDF;
                end
            end
            S_CDF: begin
                if (r_pix_cnt == C_LAST_BIN) begin
                    w_next = S_MAP;
                end
            end
            S_MAP: begin
                if (r_pix_cnt == C_LAST_PIX) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (rdn_in_ready) begin
                    w_next = S_LOAD;
                end
            end
            default: begin
                w_next = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_pix_cnt  <= '0;
            r_acc      <= '0;
            r_img      <= '0;
            r_hist     <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (r_beat_cnt == BW'(b)) begin
                                r_img[b*BEAT_PIX +: BEAT_PIX] <= in_beat;
                            end
                        end
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_last_beat) begin
                            r_hist    <= '0;
                            r_pix_cnt <= '0;
                            r_acc     <= '0;
                        end
                    end
                end
                S_HIST: begin
                    r_hist[w_pix] <= w_hist_pix + 1'b1;
                    r_pix_cnt     <= (r_pix_cnt == C_LAST_PIX) ? '0 : r_pix_cnt + 1'b1;
                end
                S_CDF: begin
                    // Running sum replaces each bin in place, turning it into the CDF
                    r_hist[w_bin] <= w_cdf_sum;
                    r_acc         <= w_cdf_sum;
                    r_pix_cnt     <= (r_pix_cnt == C_LAST_BIN) ? '0 : r_pix_cnt + 1'b1;
                end
                S_MAP: begin
                    r_img[r_pix_cnt] <= w_map;
                    r_pix_cnt        <= (r_pix_cnt == C_LAST_PIX) ? '0 : r_pix_cnt + 1'b1;
                end
                S_OUT: begin
                    if (rdn_in_ready) begin
                        r_beat_cnt <= '0;
                    end
                end
                default: begin
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_heu_eq.sv
`default_nettype none
// ============================================================================
// Module   : tb_heu_eq
// Purpose  : Directed self-checking bench for heu_eq (equalisation, latency,
//            backpressure, beat gaps, mid-operation reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_heu_eq;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [79:0][7:0]       in_beat;
    logic                   rdn_in_ready;
    logic                   out_valid;
    logic [4:0][79:0][7:0]  out_img;

    int passed = 0;
    int total  = 0;
    int failed = 0;
    int lat;
    logic [7:0] win  [0:399];
    logic [7:0] expv [0:399];

    always #5 clk = ~clk;

    heu_eq dut (
        .clk          (clk),
        .rst          (rst),
`ifdef HEU_BYPASS_EN
        .bypass       (1'b0),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_beat      (in_beat),
        .rdn_in_ready (rdn_in_ready),
        .out_valid    (out_valid),
        .out_img      (out_img)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int n);
        return out_img[n / 80][n % 80];
    endfunction

    task automatic send_window(input bit gaps);
        for (int b = 0; b < 5; b++) begin
            for (int c = 0; c < 80; c++) in_beat[c] = win[b*80 + c];
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (gaps && b < 4) begin
                repeat (2) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic wait_out();
        lat = 0;
        while (out_valid !== 1'b1 && lat < 1500) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_img(input string tag);
        int bad;
        bad = 0;
        for (int n = 0; n < 400; n++) if (pix(n) !== expv[n]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic release_out(input string tag);
        rdn_in_ready = 1'b1;
        @(posedge clk); #1;
        rdn_in_ready = 1'b0;
        chk({tag, "_rel_valid"}, out_valid, 0);
        chk({tag, "_rel_ready"}, in_ready, 1);
    endtask

    initial begin
        int bad_v, bad_r, bad_i;
        rst = 1'b1; in_valid = 1'b0; rdn_in_ready = 1'b0; in_beat = '0;
        repeat (2) @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_img0", pix(0), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", in_ready, 1);

        // Constant 100 window, back-to-back beats
        for (int n = 0; n < 400; n++) begin win[n] = 8'd100; expv[n] = 8'd255; end
        send_window(1'b0);
        chk("const_ready_busy", in_ready, 0);
        wait_out();
        chk("const_latency", lat, 1056);
        check_img("const_img");

        // Backpressure: stall in OUT while upstream keeps offering a beat
        in_valid = 1'b1;
        for (int c = 0; c < 80; c++) in_beat[c] = 8'hAA;
        bad_v = 0; bad_r = 0; bad_i = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1) bad_v++;
            if (in_ready !== 1'b0) bad_r++;
            for (int n = 0; n < 400; n++) if (pix(n) !== expv[n]) bad_i++;
        end
        in_valid = 1'b0;
        chk("bp_valid_held", bad_v, 0);
        chk("bp_ready_low", bad_r, 0);
        chk("bp_img_stable", bad_i, 0);
        release_out("bp");

        // Half/half window with gaps between beats
        for (int n = 0; n < 400; n++) begin
            win[n]  = (n < 200) ? 8'd0   : 8'd255;
            expv[n] = (n < 200) ? 8'd127 : 8'd255;
        end
        send_window(1'b1);
        wait_out();
        chk("half_latency", lat, 1056);
        check_img("half_img");
        release_out("half");

        // Ramp: pixel n = n mod 256
        for (int n = 0; n < 400; n++) win[n] = 8'(n % 256);
        send_window(1'b0);
        wait_out();
        chk("ramp_latency", lat, 1056);
        chk("ramp_n0", pix(0), 1);
        chk("ramp_n143", pix(143), 183);
        chk("ramp_n144", pix(144), 184);
        chk("ramp_n200", pix(200), 219);
        chk("ramp_n255", pix(255), 255);
        chk("ramp_n256", pix(256), 1);
        chk("ramp_n399", pix(399), 183);
        release_out("ramp");

        // Reset 200 cycles into HIST
        for (int n = 0; n < 400; n++) win[n] = 8'd77;
        send_window(1'b0);
        repeat (200) @(posedge clk);
        #1;
        chk("mid_busy_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_after_ready", in_ready, 1);

        for (int n = 0; n < 400; n++) begin win[n] = 8'd50; expv[n] = 8'd255; end
        send_window(1'b0);
        wait_out();
        chk("c50_latency", lat, 1056);
        check_img("c50_img");
        release_out("c50");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
